// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds FSM states, funct3 encodings and lane count.
package riscv_lsu_pkg;

    localparam int LSU_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = LSU_DATA_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid response.
// master = load/store unit, slave = memory.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the bus word down to the
// addressed lane and sign/zero-extend to full width.
module lsu_load_align
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        unique case (funct3)
            F3_B:  data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:  data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_BU: data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU: data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: sized loads/stores over a req/gnt/rvalid
// bus, stalling the core while an access is outstanding.
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    load_store_unit_if.master     bus
);

    lsu_state_t state_q, state_d;

    logic                  any_req;
    logic                  f3_bad;
    logic                  misalign;
    logic                  bad;
    logic                  idle;
    logic                  start;
    logic [BE_WIDTH-1:0]   be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] load_data;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign any_req = mem_read | mem_write;
    assign idle    = (state_q == IDLE);

    // Unsigned encodings only make sense for loads.
    always_comb begin
        f3_bad = 1'b1;
        unique case (funct3)
            F3_B, F3_H, F3_W: f3_bad = 1'b0;
            F3_BU, F3_HU:     f3_bad = mem_write;
            default:          f3_bad = 1'b1;
        endcase
    end

    assign misalign = ((funct3[1:0] == 2'b01) & addr[0])
                    | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

    assign bad   = (mem_read & mem_write) | f3_bad | misalign;
    assign err   = any_req & idle & bad;
    assign start = any_req & idle & ~bad;

    always_comb begin
        be_d    = '1;
        wdata_d = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_d    = BE_WIDTH'(1) << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d    = BE_WIDTH'(3) << addr[1:0];
                wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d    = '1;
                wdata_d = wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (bus.gnt) state_d = we_q ? DONE : WAIT_R;
            WAIT_R:  if (bus.rvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .word  (bus.rdata),
        .offset(off_q),
        .funct3(f3_q),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                we_q    <= mem_write;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                off_q   <= addr[1:0];
                f3_q    <= funct3;
            end
            if ((state_q == WAIT_R) && bus.rvalid)
                rdata_q <= load_data;
        end
    end

    assign busy      = start | (state_q == REQ) | (state_q == WAIT_R);
    assign done      = (state_q == DONE);
    assign rdata     = rdata_q;
    assign bus.req   = (state_q == REQ);
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table
// with a load-data scoreboard plus reset/back-to-back cases.
module tb_load_store_unit;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          waits;
        logic        xerr;
        logic [3:0]  xbe;
        logic [31:0] xaddr;
        logic [31:0] xwdata;
        logic [31:0] xrdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;
    logic [31:0] sb_q[$];

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rw,
                                input int waits, input logic xerr,
                                input logic [3:0] xbe, input logic [31:0] xwd,
                                input logic [31:0] xrd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.rword = rw; v.waits = waits;
        v.xerr = xerr; v.xbe = xbe;
        v.xaddr = {a[31:2], 2'b00};
        v.xwdata = xwd; v.xrdata = xrd;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr      = '0;
        wdata     = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] exp;
        @(posedge clk); #1;
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b0;
        #1;
        chk("err", err, v.xerr);
        chk("done_idle", done, 1'b0);
        if (v.xerr) begin
            chk("busy_err", busy, 1'b0);
            chk("req_err", bus_if.req, 1'b0);
            @(posedge clk); #1;
            chk("req_err_hold", bus_if.req, 1'b0);
            chk("rdata_err_hold", rdata, last_rdata);
            idle_inputs();
            return;
        end
        chk("busy_start", busy, 1'b1);
        if (v.rd) sb_q.push_back(v.xrdata);
        @(posedge clk); #1;
        chk("req", bus_if.req, 1'b1);
        chk("busy_req", busy, 1'b1);
        chk("bus_addr", bus_if.addr, v.xaddr);
        chk("bus_be", {28'd0, bus_if.be}, {28'd0, v.xbe});
        chk("bus_we", bus_if.we, v.wr);
        if (v.wr) chk("bus_wdata", bus_if.wdata, v.xwdata);
        for (int i = 0; i < v.waits; i++) begin
            @(posedge clk); #1;
            chk("req_wait", bus_if.req, 1'b1);
            chk("addr_wait", bus_if.addr, v.xaddr);
            if (v.wr) chk("wdata_wait", bus_if.wdata, v.xwdata);
        end
        bus_if.gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.gnt = 1'b0;
        if (v.rd) begin
            chk("busy_waitr", busy, 1'b1);
            chk("req_waitr", bus_if.req, 1'b0);
            bus_if.rvalid = 1'b1;
            bus_if.rdata  = v.rword;
            @(posedge clk); #1;
            bus_if.rvalid = 1'b0;
            bus_if.rdata  = 32'h5A5A5A5A;
        end
        chk("done", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("req_done", bus_if.req, 1'b0);
        if (v.rd) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                chk("rdata", rdata, exp);
                last_rdata = exp;
            end
        end else begin
            chk("rdata_store_hold", rdata, last_rdata);
        end
        idle_inputs();
    endtask

    vec_t tbl[15];
    vec_t b2b[2];

    initial begin
        tbl[0]  = mk(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0,
                     4'b1111, 0, 32'hDEADBEEF);
        tbl[1]  = mk(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 0,
                     4'b1000, 0, 32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 0, 0,
                     4'b1000, 0, 32'h00000080);
        tbl[3]  = mk(1, 0, 3'b001, 32'h102, 0, 32'h80123456, 1, 0,
                     4'b1100, 0, 32'hFFFF8012);
        tbl[4]  = mk(1, 0, 3'b101, 32'h102, 0, 32'h80123456, 0, 0,
                     4'b1100, 0, 32'h00008012);
        tbl[5]  = mk(1, 0, 3'b000, 32'h101, 0, 32'h80123456, 0, 0,
                     4'b0010, 0, 32'h00000034);
        tbl[6]  = mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 3, 0,
                     4'b1100, 32'hABCDABCD, 0);
        tbl[7]  = mk(0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 0,
                     4'b0010, 32'hA5A5A5A5, 0);
        tbl[8]  = mk(0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 0, 1, 0,
                     4'b1111, 32'hCAFEF00D, 0);
        tbl[9]  = mk(1, 0, 3'b010, 32'h101, 0, 0, 0, 1, 0, 0, 0);
        tbl[10] = mk(0, 1, 3'b001, 32'h203, 0, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(1, 0, 3'b011, 32'h100, 0, 0, 0, 1, 0, 0, 0);
        tbl[12] = mk(1, 1, 3'b010, 32'h100, 0, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 3'b100, 32'h100, 0, 0, 0, 1, 0, 0, 0);
        tbl[14] = mk(1, 0, 3'b101, 32'h105, 0, 0, 0, 1, 0, 0, 0);
        b2b[0]  = mk(1, 0, 3'b001, 32'h10A, 0, 32'h80015555, 0, 0,
                     4'b1100, 0, 32'hFFFF8001);
        b2b[1]  = mk(0, 1, 3'b010, 32'h500, 32'h11223344, 0, 0, 0,
                     4'b1111, 32'h11223344, 0);

        idle_inputs();
        bus_if.gnt    = 1'b0;
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = '0;
        last_rdata    = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_req", bus_if.req, 0);
        chk("rst_we", bus_if.we, 0);
        chk("rst_addr", bus_if.addr, 0);
        chk("rst_be", {28'd0, bus_if.be}, 0);
        chk("rst_wdata", bus_if.wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // Reset while a load waits for rvalid, then a stray rvalid.
        @(posedge clk); #1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h100;
        @(posedge clk); #1;
        bus_if.gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.gnt = 1'b0;
        idle_inputs();
        chk("rw_busy_waitr", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rw_req", bus_if.req, 0);
        chk("rw_done", done, 0);
        chk("rw_rdata", rdata, 0);
        chk("rw_busy", busy, 0);
        chk("rw_addr", bus_if.addr, 0);
        rst_n = 1'b1;
        last_rdata = '0;
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_if.rvalid = 1'b0;
        chk("stray_done", done, 0);
        chk("stray_rdata", rdata, 0);
        chk("stray_busy", busy, 0);
        @(posedge clk); #1;
        chk("stray_done2", done, 0);
        chk("stray_req2", bus_if.req, 0);

        run_vec(b2b[0]);
        run_vec(b2b[1]);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
